svreal_mul_sched: RTL

- Round-robin scheduler that shares one pipelined fixed-point multiplier among N_REQ requesters.
- Each requester presents two fixed-point operands with a valid/ready handshake.
- The block grants at most one requester per cycle and aligns the product to the output exponent, using the same shift and truncate rules as an svreal assignment.
- Results leave through a single valid/ready output tagged with the requester index. It sits between svreal datapath producers and a consumer that can only afford one multiplier.

---
 rtl/svreal_mul_sched_if.sv | 27 ++
 rtl/svreal_mul_sched.sv | 130 +++++++++++++
 2 files changed

// File: rtl/svreal_mul_sched_if.sv
// Bundle of the requester-side and result-side handshakes of svreal_mul_sched.
// valid/ready: a transfer happens on a rising edge where valid && ready; payload is held while valid && !ready.
interface svreal_mul_sched_if #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 16,
  parameter int ID_W      = (N_REQ > 2) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_WIDTH-1:0]   out_data;
  logic [ID_W-1:0]        out_id;

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/svreal_mul_sched.sv
// Round-robin scheduler sharing one pipelined signed fixed-point multiplier among N_REQ requesters;
// products are re-aligned to EXP_OUT with svreal shift/truncate semantics and tagged with the requester index.
module svreal_mul_sched #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int EXP_A     = -12,
  parameter int EXP_B     = -12,
  parameter int OUT_WIDTH = 16,
  parameter int EXP_OUT   = -12,
  parameter int LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  svreal_mul_sched_if.slave     bus,
  output logic                  busy
);

  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int PW   = 2 * WIDTH;
  localparam int SH   = EXP_A + EXP_B - EXP_OUT;
  localparam int LSH  = (SH > 0) ? SH : 0;
  localparam int RSH  = (SH < 0) ? -SH : 0;
  localparam int AW   = (PW + LSH > OUT_WIDTH) ? PW + LSH : OUT_WIDTH;

  logic                     out_valid_q;
  logic [OUT_WIDTH-1:0]     out_data_q;
  logic [ID_W-1:0]          out_id_q;
  logic [ID_W-1:0]          ptr;
  logic                     advance;
  logic                     grant_found;
  logic [ID_W-1:0]          grant_idx;
  logic                     hs;
  logic signed [WIDTH-1:0]  a_sel;
  logic signed [WIDTH-1:0]  b_sel;
  logic signed [PW-1:0]     prod_now;

  // Arithmetic shifts give floor rounding on the right and wrap on the left; truncation keeps the low bits.
  function automatic logic [OUT_WIDTH-1:0] align(input logic signed [PW-1:0] p);
    logic signed [AW-1:0] ext;
    ext = AW'(p);
    if (SH >= 0) align = OUT_WIDTH'(ext <<< LSH);
    else         align = OUT_WIDTH'(ext >>> RSH);
  endfunction

  assign advance = !out_valid_q || bus.out_ready;

  // Search upward from the slot after the last grant so every requester waits at most N_REQ-1 grants.
  always_comb begin
    int j;
    j           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!grant_found && bus.req_valid[ID_W'(j)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
  end

  assign hs = grant_found && advance;

  always_comb begin
    bus.req_ready = '0;
    if (hs) bus.req_ready[grant_idx] = 1'b1;
  end

  assign a_sel    = bus.req_a[grant_idx*WIDTH +: WIDTH];
  assign b_sel    = bus.req_b[grant_idx*WIDTH +: WIDTH];
  assign prod_now = PW'(a_sel) * PW'(b_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr <= ID_W'(N_REQ - 1);
    else if (hs) ptr <= grant_idx;
  end

  generate
    if (LATENCY == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          out_id_q    <= '0;
        end else if (advance) begin
          out_valid_q <= hs;
          out_data_q  <= align(prod_now);
          out_id_q    <= grant_idx;
        end
      end
      assign busy = out_valid_q;
    end else begin : g_multi
      // Stages 0..LATENCY-2 carry the full-width product; alignment happens on entry to the output register.
      logic [LATENCY-2:0]   sv;
      logic signed [PW-1:0] sp  [LATENCY-1];
      logic [ID_W-1:0]      sid [LATENCY-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sv          <= '0;
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          out_id_q    <= '0;
          for (int i = 0; i < LATENCY - 1; i++) begin
            sp[i]  <= '0;
            sid[i] <= '0;
          end
        end else if (advance) begin
          sv[0]  <= hs;
          sp[0]  <= prod_now;
          sid[0] <= grant_idx;
          for (int i = 1; i < LATENCY - 1; i++) begin
            sv[i]  <= sv[i-1];
            sp[i]  <= sp[i-1];
            sid[i] <= sid[i-1];
          end
          out_valid_q <= sv[LATENCY-2];
          out_data_q  <= align(sp[LATENCY-2]);
          out_id_q    <= sid[LATENCY-2];
        end
      end
      assign busy = out_valid_q || (|sv);
    end
  endgenerate

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;

endmodule
